// File: rtl/fetch_pkg.sv
// Shared widths and the buffered fetch entry type for the instruction fetch slice.
package fetch_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int INSTR_W_DEF     = 32;
  localparam int FETCH_DEPTH_DEF = 4;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetch entries with flush. The head is visible while the
// FIFO is non-empty; when empty the head output holds whatever it last showed.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = FETCH_DEPTH_DEF,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t             mem [DEPTH];
  entry_t             head_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Flush wins over push; pop is ignored on an empty FIFO.
  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && (count != '0);
    head    = (count != '0) ? mem[rd_ptr] : head_q;
  end

  // Storage array needs no reset: nothing is shown from it while count is 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Remember the currently shown head so it can be held once the FIFO empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) head_q <= '0;
    else       head_q <= head;
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the PC, reads a 1-cycle-latency imem, buffers
// returned words with their PC and hands them to decode.
//
// Handshake: decode takes the head word in any cycle where instr_valid and
// instr_ready are both 1. instr_valid never depends on instr_ready, and
// instr_data/instr_pc stay stable while instr_valid=1 and instr_ready=0.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = FETCH_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic              rsp_pending;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic              issue;
  logic              push;
  logic              pop;
  entry_t            rsp_entry;
  entry_t            head;

  // Credit rule: a slot is reserved for every buffered word and for the read
  // still in flight, so a response can never land in a full buffer.
  always_comb begin
    credit_used     = {1'b0, count} + (CNT_W+1)'(rsp_pending);
    issue           = !reset && !halt && !jump_valid &&
                      (credit_used < (CNT_W+1)'(DEPTH));
    imem_en         = issue;
    imem_addr       = fetch_pc;
    push            = rsp_pending && !jump_valid;
    pop             = instr_valid && instr_ready;
    rsp_entry.pc    = rsp_pc;
    rsp_entry.instr = imem_rdata;
    instr_valid     = (count != '0);
    instr_data      = head.instr;
    instr_pc        = head.pc;
  end

  // PC generation: a jump reloads the PC, otherwise it advances on each issue
  // and wraps naturally at the address width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      rsp_pc      <= '0;
      rsp_pending <= 1'b0;
    end else begin
      rsp_pending <= issue;
      if (issue) rsp_pc <= fetch_pc;
      if (jump_valid) fetch_pc <= jump_addr;
      else if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .flush     (jump_valid),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized phase, all
// checked against an in-order reference model of issued/delivered PCs.
module tb_instr_fetch_unit;

  localparam int AW    = 8;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          halt;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  // Synchronous imem: data for an address appears the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= {24'hA5A5A5, imem_addr};
  end

  // ---------------- scoreboard / model state ----------------
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  logic [AW-1:0] exp_q [$];   // PCs issued and not yet delivered, in order
  int            iss_q [$];   // issue cycle of each entry in exp_q
  logic [AW-1:0] model_pc;
  logic [AW-1:0] held_pc;
  logic [IW-1:0] held_data;
  logic [AW-1:0] got_pc [$];
  int            got_cyc [$];
  int            issue_cnt;
  int            first_en_cyc;
  int            first_val_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] got_at(input int i);
    if (i < got_pc.size()) return got_pc[i];
    return '0;
  endfunction

  function automatic int got_cyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    iss_q.delete();
    model_pc  = '0;
    held_pc   = '0;
    held_data = '0;
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic cycle();
    logic exp_en;
    logic exp_val;
    @(negedge clk);
    if (!reset) begin
      exp_val = (exp_q.size() > 0) && (iss_q[0] <= cyc - 2);
      exp_en  = !halt && !jump_valid && (exp_q.size() < DEPTH);
      chk("instr_valid", 64'(instr_valid), 64'(exp_val));
      chk("imem_en", 64'(imem_en), 64'(exp_en));
      if (exp_en) chk("imem_addr", 64'(imem_addr), 64'(model_pc));
      if (instr_valid) begin
        held_pc   = instr_pc;
        held_data = instr_data;
      end else begin
        chk("hold_pc", 64'(instr_pc), 64'(held_pc));
        chk("hold_data", 64'(instr_data), 64'(held_data));
      end
      if (exp_val && instr_ready) begin
        chk("xfer_pc", 64'(instr_pc), 64'(exp_q[0]));
        chk("xfer_data", 64'(instr_data), 64'({24'hA5A5A5, exp_q[0]}));
        got_pc.push_back(instr_pc);
        got_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        void'(iss_q.pop_front());
      end
      if (imem_en) issue_cnt++;
      if (imem_en && first_en_cyc < 0) first_en_cyc = cyc;
      if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (jump_valid) begin
        exp_q.delete();
        iss_q.delete();
        model_pc = jump_addr;
      end else if (exp_en) begin
        exp_q.push_back(model_pc);
        iss_q.push_back(cyc);
        model_pc = model_pc + 8'd1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Assert reset (possibly mid-cycle), check reset outputs, release after the
  // second following rising edge.
  task automatic do_reset();
    reset       = 1'b1;
    halt        = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = '0;
    instr_ready = 1'b0;
    #1;
    chk("rst_imem_en", 64'(imem_en), 64'(0));
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_data", 64'(instr_data), 64'(0));
    chk("rst_pc", 64'(instr_pc), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    int  bound;
    int  jcyc;
    int  halt_issues;
    logic found;

    // ---- streaming from reset: latency and throughput ----
    do_reset();
    instr_ready   = 1'b1;
    first_en_cyc  = -1;
    first_val_cyc = -1;
    got_pc.delete(); got_cyc.delete();
    repeat (12) cycle();
    chk("first_latency", 64'(first_val_cyc - first_en_cyc), 64'(2));
    chk("t1_len", 64'(got_pc.size() >= 3), 64'(1));
    chk("t1_pc0", 64'(got_at(0)), 64'(8'h00));
    chk("t1_pc1", 64'(got_at(1)), 64'(8'h01));
    chk("t1_pc2", 64'(got_at(2)), 64'(8'h02));
    chk("t1_back_to_back", 64'(got_cyc_at(2) - got_cyc_at(0)), 64'(2));

    // ---- backpressure from reset: buffer fills, then drains in order ----
    do_reset();
    instr_ready = 1'b0;
    issue_cnt   = 0;
    repeat (10) cycle();
    chk("bp_issues", 64'(issue_cnt), 64'(4));
    chk("bp_head_data", 64'(instr_data), 64'(32'hA5A5A500));
    chk("bp_head_pc", 64'(instr_pc), 64'(8'h00));
    instr_ready = 1'b1;
    got_pc.delete(); got_cyc.delete();
    repeat (8) cycle();
    for (int i = 0; i < 5; i++) chk("bp_drain_pc", 64'(got_at(i)), 64'(i));

    // ---- jump to 0x40 while pc 5 is at the head ----
    do_reset();
    instr_ready = 1'b1;
    found = 1'b0;
    bound = 0;
    while (!found && bound < 30) begin
      if (instr_valid && instr_pc == 8'h05) found = 1'b1;
      else begin
        cycle();
        bound++;
      end
    end
    chk("wait_pc5", 64'(found), 64'(1));
    got_pc.delete(); got_cyc.delete();
    jump_valid = 1'b1;
    jump_addr  = 8'h40;
    jcyc       = cyc;
    cycle();
    jump_valid = 1'b0;
    repeat (8) cycle();
    chk("jmp_last_old", 64'(got_at(0)), 64'(8'h05));
    chk("jmp_first_new", 64'(got_at(1)), 64'(8'h40));
    chk("jmp_latency", 64'(got_cyc_at(1) - jcyc), 64'(3));

    // ---- jump to 0xFE: address wrap ----
    jump_valid = 1'b1;
    jump_addr  = 8'hFE;
    cycle();
    jump_valid = 1'b0;
    got_pc.delete(); got_cyc.delete();
    repeat (8) cycle();
    chk("wrap_0", 64'(got_at(0)), 64'(8'hFE));
    chk("wrap_1", 64'(got_at(1)), 64'(8'hFF));
    chk("wrap_2", 64'(got_at(2)), 64'(8'h00));
    chk("wrap_3", 64'(got_at(3)), 64'(8'h01));

    // ---- halt mid-stream for 10 cycles: no issue, buffer still drains ----
    halt        = 1'b1;
    instr_ready = 1'b0;
    issue_cnt   = 0;
    repeat (5) cycle();
    instr_ready = 1'b1;
    repeat (5) cycle();
    halt_issues = issue_cnt;
    chk("halt_no_issue", 64'(halt_issues), 64'(0));
    chk("halt_drained", 64'(instr_valid), 64'(0));
    halt = 1'b0;
    repeat (8) cycle();

    // ---- randomized traffic: ready, halt and jumps ----
    for (int n = 0; n < 600; n++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      jump_valid = ($urandom_range(0, 24) == 0);
      jump_addr  = AW'($urandom_range(0, 255));
      cycle();
    end
    halt       = 1'b0;
    jump_valid = 1'b0;
    repeat (4) cycle();

    // ---- asynchronous reset with 3 words buffered ----
    do_reset();
    instr_ready = 1'b0;
    repeat (4) cycle();
    chk("pre_rst_valid", 64'(instr_valid), 64'(1));
    #3;
    do_reset();
    instr_ready = 1'b1;
    got_pc.delete(); got_cyc.delete();
    repeat (6) cycle();
    chk("post_rst_pc0", 64'(got_at(0)), 64'(8'h00));
    chk("post_rst_pc1", 64'(got_at(1)), 64'(8'h01));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
